// File: rtl/cdb_arbiter_pkg.sv
// Shared result types for the CDB path: ROB id, data word and the broadcast record.
package cdb_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  rob_id_t;

  typedef struct packed {
    rob_id_t rob_id;
    logic    r_valid;
    word_t   w_data;
  } cdb_info_t;

  localparam int unsigned CDB_SRC_COUNT = 4;

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result buffer: power-of-two ring with naturally wrapping pointers.
module result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  T                mem_q [DEPTH];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [PtrW:0]   cnt_q;
  logic            do_push, do_pop;

  assign full    = (cnt_q == (PtrW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

  // Storage needs no reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Collects execute results into per-source FIFOs and broadcasts up to CDB_COUNT
// per cycle on the CDB, scanning sources round-robin from rr_q.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned SRC_COUNT  = CDB_SRC_COUNT,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CDB_COUNT  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  cdb_info_t [SRC_COUNT-1:0]       src_result_i,
  input  logic      [SRC_COUNT-1:0]       src_valid_i,
  output logic      [SRC_COUNT-1:0]       src_ready_o,
  output cdb_info_t [CDB_COUNT-1:0]       cdb_info_o,
  output word_t     [CDB_COUNT-1:0]       cdb_data_o,
  output rob_id_t   [CDB_COUNT-1:0]       cdb_reg_id_o,
  output logic      [CDB_COUNT-1:0]       cdb_valid_o
);

  localparam int unsigned SrcW = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;

  logic      [SrcW-1:0]      rr_q, rr_d;
  logic      [SRC_COUNT-1:0] full, empty, pop;
  cdb_info_t [SRC_COUNT-1:0] head;

  for (genvar s = 0; s < SRC_COUNT; s++) begin : g_fifo
    result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (cdb_info_t)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (src_valid_i[s]),
      .wdata (src_result_i[s]),
      .pop   (pop[s]),
      .full  (full[s]),
      .empty (empty[s]),
      .head  (head[s])
    );
  end

  // Ready comes from the registered count only, so a full FIFO bubbles once after a pop.
  assign src_ready_o = ~full;

  always_comb begin
    int unsigned     n;
    int unsigned     idx;
    logic [SrcW-1:0] src;
    logic [SrcW-1:0] last;
    pop         = '0;
    cdb_valid_o = '0;
    cdb_info_o  = '0;
    n           = 0;
    idx         = 0;
    src         = '0;
    last        = rr_q;
    rr_d        = rr_q;
    for (int unsigned i = 0; i < SRC_COUNT; i++) begin
      idx = i + 32'(rr_q);
      if (idx >= SRC_COUNT) idx = idx - SRC_COUNT;
      src = SrcW'(idx);
      if (!rst && !flush && !empty[src] && n < CDB_COUNT) begin
        pop[src] = 1'b1;
        for (int unsigned p = 0; p < CDB_COUNT; p++) begin
          if (p == n) begin
            cdb_valid_o[p] = 1'b1;
            cdb_info_o[p]  = head[src];
          end
        end
        last = src;
        n    = n + 1;
      end
    end
    if (n != 0) rr_d = (last == SrcW'(SRC_COUNT - 1)) ? '0 : last + 1'b1;
  end

  for (genvar p = 0; p < CDB_COUNT; p++) begin : g_port
    assign cdb_data_o[p]   = cdb_info_o[p].w_data;
    assign cdb_reg_id_o[p] = cdb_info_o[p].rob_id;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) rr_q <= '0;
    else              rr_q <= rr_d;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, back-pressure sequence and a random
// soak, all checked against a queue-based reference model plus a starvation monitor.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned SRC = 4;
  localparam int unsigned DEP = 2;
  localparam int unsigned CDB = 2;

  logic                clk = 1'b0;
  logic                rst, flush;
  cdb_info_t [SRC-1:0] src_result;
  logic      [SRC-1:0] src_valid, src_ready;
  cdb_info_t [CDB-1:0] cdb_info;
  word_t     [CDB-1:0] cdb_data;
  rob_id_t   [CDB-1:0] cdb_reg_id;
  logic      [CDB-1:0] cdb_valid;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .SRC_COUNT  (SRC),
    .FIFO_DEPTH (DEP),
    .CDB_COUNT  (CDB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .src_result_i (src_result),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready),
    .cdb_info_o   (cdb_info),
    .cdb_data_o   (cdb_data),
    .cdb_reg_id_o (cdb_reg_id),
    .cdb_valid_o  (cdb_valid)
  );

  int total = 0;
  int bad   = 0;

  cdb_info_t mq [SRC][$];
  int        rr_m = 0;
  int        starve [SRC];
  int        seen [SRC];

  typedef struct {
    logic       r;
    logic       f;
    logic [3:0] v;
    logic [1:0] ev;
    logic [3:0] er;
    int         s0;
    int         t0;
    int         s1;
    int         t1;
  } vec_t;

  vec_t tbl [15];

  function automatic cdb_info_t mk(int s, int tag);
    cdb_info_t r;
    r.rob_id  = rob_id_t'(tag);
    r.r_valid = tag[5];
    r.w_data  = {s[1:0], 14'h2A5, tag[15:0]};
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: oldest result per source, scan from rr_m, take up to CDB non-empty sources.
  task automatic model_step(output logic [SRC-1:0] acc);
    logic [CDB-1:0] ev;
    cdb_info_t      ei [CDB];
    int             gs [$];
    logic [SRC-1:0] rdy;
    logic           hit;
    int             n;
    ev = '0;
    n  = 0;
    for (int p = 0; p < CDB; p++) ei[p] = '0;
    if (!rst && !flush) begin
      for (int i = 0; i < SRC; i++) begin
        int s;
        s = (rr_m + i) % SRC;
        if (mq[s].size() > 0 && n < CDB) begin
          ev[n] = 1'b1;
          ei[n] = mq[s][0];
          gs.push_back(s);
          n++;
        end
      end
    end
    chk("cdb_valid", 64'(cdb_valid), 64'(ev));
    for (int p = 0; p < CDB; p++) begin
      chk("cdb_info", 64'(cdb_info[p]), 64'(ei[p]));
      chk("cdb_data", 64'(cdb_data[p]), 64'(ei[p].w_data));
      chk("cdb_reg_id", 64'(cdb_reg_id[p]), 64'(ei[p].rob_id));
    end
    for (int s = 0; s < SRC; s++) rdy[s] = (mq[s].size() < DEP);
    chk("src_ready", 64'(src_ready), 64'(rdy));
    // Starvation is judged on what the DUT actually broadcast.
    for (int s = 0; s < SRC; s++) begin
      hit = 1'b0;
      for (int p = 0; p < CDB; p++)
        if (cdb_valid[p] && cdb_info[p].w_data[31:30] == 2'(s)) hit = 1'b1;
      if (hit) seen[s]++;
      if (!rst && !flush && mq[s].size() > 0 && !hit) starve[s]++;
      else starve[s] = 0;
      chk("starve_bound", 64'(starve[s] <= 1), 64'd1);
    end
    for (int s = 0; s < SRC; s++) acc[s] = !rst && !flush && src_valid[s] && rdy[s];
    if (rst || flush) begin
      for (int s = 0; s < SRC; s++) mq[s].delete();
      rr_m = 0;
    end else begin
      foreach (gs[k]) void'(mq[gs[k]].pop_front());
      if (gs.size() > 0) rr_m = (gs[gs.size()-1] + 1) % SRC;
      for (int s = 0; s < SRC; s++) if (acc[s]) mq[s].push_back(src_result[s]);
    end
  endtask

  task automatic tick(output logic [SRC-1:0] acc);
    @(negedge clk);
    model_step(acc);
    @(posedge clk);
    #1;
  endtask

  function automatic int model_total();
    int t;
    t = 0;
    for (int s = 0; s < SRC; s++) t += mq[s].size();
    return t;
  endfunction

  logic [SRC-1:0] acc;
  logic           cur_v [SRC];
  int             seq [SRC];
  int             seen0 [SRC];
  int             seq1, seen1_start;
  logic           saw_low;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 4'b0000, 2'b00, 4'hF, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0100, 2'b00, 4'hF, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 4'b0000, 2'b01, 4'hF, 2, 1, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 4'b0000, 2'b00, 4'hF, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 4'b1111, 2'b00, 4'hF, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 4'b0000, 2'b11, 4'hF, 0, 4, 1, 4};
    tbl[6]  = '{1'b0, 1'b0, 4'b0000, 2'b11, 4'hF, 2, 4, 3, 4};
    tbl[7]  = '{1'b0, 1'b0, 4'b0000, 2'b00, 4'hF, 0, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 4'b1001, 2'b00, 4'hF, 0, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 4'b1001, 2'b11, 4'hF, 0, 8, 3, 8};
    tbl[10] = '{1'b0, 1'b1, 4'b0010, 2'b00, 4'hF, 0, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 4'b0000, 2'b00, 4'hF, 0, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b0, 4'b0001, 2'b00, 4'hF, 0, 0, 0, 0};
    tbl[13] = '{1'b1, 1'b0, 4'b0000, 2'b00, 4'hF, 0, 0, 0, 0};
    tbl[14] = '{1'b0, 1'b0, 4'b0000, 2'b00, 4'hF, 0, 0, 0, 0};

    for (int s = 0; s < SRC; s++) begin
      starve[s] = 0;
      seen[s]   = 0;
      seq[s]    = 0;
      cur_v[s]  = 1'b0;
    end
    rst        = 1'b1;
    flush      = 1'b0;
    src_valid  = '0;
    src_result = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 10; c++) tick(acc);

    // Directed vector table.
    for (int k = 0; k < 15; k++) begin
      rst       = tbl[k].r;
      flush     = tbl[k].f;
      src_valid = tbl[k].v;
      for (int s = 0; s < SRC; s++) src_result[s] = mk(s, k);
      @(negedge clk);
      chk("tbl_valid", 64'(cdb_valid), 64'(tbl[k].ev));
      chk("tbl_ready", 64'(src_ready), 64'(tbl[k].er));
      if (tbl[k].ev[0]) begin
        chk("tbl_p0_info", 64'(cdb_info[0]), 64'(mk(tbl[k].s0, tbl[k].t0)));
        chk("tbl_p0_data", 64'(cdb_data[0]), 64'(mk(tbl[k].s0, tbl[k].t0).w_data));
        chk("tbl_p0_reg", 64'(cdb_reg_id[0]), 64'(rob_id_t'(tbl[k].t0)));
      end else begin
        chk("tbl_p0_zero", 64'(cdb_info[0]), 64'd0);
      end
      if (tbl[k].ev[1]) begin
        chk("tbl_p1_info", 64'(cdb_info[1]), 64'(mk(tbl[k].s1, tbl[k].t1)));
        chk("tbl_p1_reg", 64'(cdb_reg_id[1]), 64'(rob_id_t'(tbl[k].t1)));
      end else begin
        chk("tbl_p1_zero", 64'(cdb_info[1]), 64'd0);
      end
      model_step(acc);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    flush     = 1'b0;
    src_valid = '0;

    // Back-pressure: src1 offers three results, others flood; src1 holds data until taken.
    seq1        = 0;
    seen1_start = seen[1];
    saw_low     = 1'b0;
    for (int c = 0; c < 40; c++) begin
      src_valid  = (c < 12) ? 4'b1101 : 4'b0000;
      src_valid[1] = (seq1 < 3);
      for (int s = 0; s < SRC; s++) src_result[s] = mk(s, 200 + c);
      src_result[1] = mk(1, 100 + seq1);
      if (!src_ready[1]) saw_low = 1'b1;
      tick(acc);
      if (acc[1]) seq1++;
    end
    chk("bp_ready_low_seen", 64'(saw_low), 64'd1);
    chk("bp_src1_accepted", 64'(seq1), 64'd3);
    chk("bp_src1_broadcast", 64'(seen[1] - seen1_start), 64'd3);
    chk("bp_drained", 64'(model_total()), 64'd0);

    // Random soak at 90% offer rate.
    src_valid = '0;
    for (int s = 0; s < SRC; s++) begin
      seq[s]   = 0;
      seen0[s] = seen[s];
    end
    for (int c = 0; c < 10000; c++) begin
      for (int s = 0; s < SRC; s++) begin
        if (!cur_v[s] && $urandom_range(99) < 90) begin
          cur_v[s]      = 1'b1;
          src_result[s] = mk(s, 1000 + seq[s]);
        end
        src_valid[s] = cur_v[s];
      end
      tick(acc);
      for (int s = 0; s < SRC; s++) begin
        if (acc[s]) begin
          cur_v[s] = 1'b0;
          seq[s]++;
        end
      end
    end
    src_valid = '0;
    for (int c = 0; c < 10; c++) tick(acc);
    chk("soak_drained", 64'(model_total()), 64'd0);
    for (int s = 0; s < SRC; s++)
      chk("soak_no_loss", 64'(seen[s] - seen0[s]), 64'(seq[s]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Consumer end of the execute-unit result handshake. Each issue queue / execute pipe presents a cdb_info_t result with a valid flag and receives a ready.
- Results are buffered per source in a small FIFO. Up to CDB_COUNT results per cycle are broadcast on the common data bus (CDB).
- The CDB feeds the ROB and the CDB forwarding inputs of every IQ. Arbitration between sources is round-robin.

Parameters:
- SRC_COUNT, 4: number of execute-unit sources.
- FIFO_DEPTH, 2: entries per source FIFO; power of two, at least 2.
- CDB_COUNT, 2: CDB broadcast ports per cycle; must be at most SRC_COUNT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  pipeline flush; discards all buffered results.
- src_result_i  in  SRC_COUNT x $bits(cdb_info_t)  per-source result.
- src_valid_i  in  SRC_COUNT  per-source result valid.
- src_ready_o  out  SRC_COUNT  per-source FIFO can accept a result.
- cdb_info_o  out  CDB_COUNT x $bits(cdb_info_t)  full result to ROB.
- cdb_data_o  out  CDB_COUNT x 32 (word_t)  the w_data field, for IQ forwarding.
- cdb_reg_id_o  out  CDB_COUNT x $bits(rob_id_t)  the rob_id field.
- cdb_valid_o  out  CDB_COUNT  port carries a valid result.

Interface (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at posedge):
  - All FIFOs empty; rr_q=0.
  - cdb_valid_o=0, cdb_info_o/cdb_data_o/cdb_reg_id_o=0.
  - src_ready_o=all ones from the first cycle after reset.
  - Reset mid-operation drops buffered entries without broadcast.
- Flush: same effect as reset on the FIFOs and rr_q. Any push presented in the flush cycle is ignored. Nothing is broadcast in the flush cycle (cdb_valid_o forced 0).
- Push:
  - src_ready_o[s] = !full[s], from registered count only; no same-cycle pop bypass.
  - Push occurs when src_valid_i[s] & src_ready_o[s] at posedge.
  - A source holding valid while ready=0 must keep its data stable; the block takes no action.
- Broadcast (combinational from FIFO heads):
  - Scan sources starting at rr_q, wrapping modulo SRC_COUNT.
  - The first non-empty source goes to port 0, the second to port 1, and so on, up to CDB_COUNT.
  - Unused ports: valid=0 and data/info driven to 0.
  - Each granted FIFO pops at posedge; the CDB has no back-pressure.
- Latency: a result pushed at edge N appears on the CDB in cycle N+1 at the earliest. Sustained throughput is 1 per source per cycle when that source is granted every cycle.
- Round-robin update:
  - If at least one grant: rr_q <= (index of the last-granted source + 1) mod SRC_COUNT.
  - If no grant: rr_q holds.
- Simultaneous push and pop on the same FIFO: allowed when not full. Count is unchanged; the head advances.
- Full FIFO:
  - ready=0 in the cycle it is full.
  - If popped this cycle, ready returns 1 the next cycle (one bubble, by design).
- Wrap-around: read/write pointers are $clog2(FIFO_DEPTH) bits with natural wrap. Count is $clog2(FIFO_DEPTH)+1 bits.
- Ordering:
  - Per source, results broadcast strictly in push order.
  - Across sources, no ordering guarantee beyond round-robin fairness.
  - A source is never starved more than ceil(SRC_COUNT/CDB_COUNT)-1 consecutive cycles while non-empty.
- Content: cdb_info_o is passed unmodified. cdb_data_o = info.w_data; cdb_reg_id_o = info.rob_id. r_valid=0 entries are still broadcast.

Decomposition:
- Shared package (a_defines): cdb_info_t, word_t, rob_id_t already exist. Add localparam CDB_SRC_COUNT for the core's source count.
- Sub-module result_fifo: parameterised DEPTH and payload type. Ports push/pop/full/empty/head, sync active-high reset plus flush clear. Instantiated SRC_COUNT times.
- The arbiter scan and rr_q live in the top.

Test Plan:
- Reset then idle: after rst, cdb_valid_o=00 and src_ready_o=1111 with no sources valid; holds for 10 cycles.
- Single push: src 2 pushes rob_id=5, w_data=0xDEADBEEF at edge N. In cycle N+1, port0 valid with reg_id 5 and data 0xDEADBEEF, port1 invalid. rr_q=3 afterwards.
- Four-way contention: all 4 sources push one result at the same edge with rr_q=0. Next cycle ports carry src0 and src1; the cycle after, src2 and src3. Then empty.
- Back-pressure: src 1 pushes 3 results back-to-back while the other sources flood. src_ready_o[1]=0 once 2 entries are buffered. All 3 results from src 1 are broadcast in push order; none are lost or duplicated.
- Flush mid-stream: fill src0 and src3 FIFOs to 2 entries, assert flush for 1 cycle while src1 pushes. The next cycles show cdb_valid_o=00, src1's push is absent, and src_ready_o=1111.
- Fairness soak: random valid at 90% on all sources for 10k cycles. Scoreboard checks per-source order, no loss, and the starvation bound of 1 cycle for SRC_COUNT=4, CDB_COUNT=2.
